// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Scoreboard-based RAW hazard detector and stall/flush sequencer for a
//   5-stage MIPS pipeline. It sits beside the ID stage and does four things:
//     - counts in-flight writers per GPR, from ID issue to WB;
//     - drives the 2-bit pause code into control_unit.pause_in;
//     - turns pause_out and the taken-branch flag into PC / IF-ID / ID-EX
//       enables, the IF/ID flush and the ID/EX bubble;
//     - keeps a saturating stall-cycle counter for performance debug.
//
//   Build option: define HAZ_WB_BYPASS_EN to let a register that is being
//   written back this cycle (count == 1) stop stalling in the WB cycle itself.
//   This matches a register file that writes in the first half-cycle. The
//   scoreboard update rules are the same in both builds.

module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 2,
    parameter int unsigned PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // ID stage instruction
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_wreg,
    input  logic                  id_regwe,
    // control_unit feedback
    input  logic                  pause_req,
    input  logic                  branch_taken,
    // WB stage writeback
    input  logic                  wb_regwe,
    input  logic [REG_ADDR_W-1:0] wb_wreg,
    // Hazard outputs
    output logic [1:0]            pause,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [PERF_W-1:0]     perf_stall_cnt
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    // FSM encoding; 2'b11 is unused and treated like RUN.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d [NUM_REGS];
    logic [PERF_W-1:0] perf_q, perf_d;

    logic in_flush;
    logic issue;
    logic inc_en;
    logic dec_en;
    logic inc_ovf;
    logic dec_udf;

    logic rs_busy;
    logic rt_busy;
    logic rs_pend;
    logic rt_pend;

    assign in_flush = (state_q == ST_FLUSH);

    // The ID slot is squashed while in FLUSH, so nothing issues from it then.
    assign issue  = id_valid && !pause_req && !in_flush;
    assign inc_en = issue && id_regwe && (id_wreg != '0);
    assign dec_en = wb_regwe && (wb_wreg != '0);

    // Scoreboard next state: +1 on issue, -1 on writeback, both cancel out.
    always_comb begin
        inc_ovf  = 1'b0;
        dec_udf  = 1'b0;
        cnt_d[0] = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_en && (id_wreg == REG_ADDR_W'(i)) &&
                !(dec_en && (wb_wreg == REG_ADDR_W'(i)))) begin
                if (cnt_q[i] == '1) begin
                    inc_ovf = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec_en && (wb_wreg == REG_ADDR_W'(i)) &&
                         !(inc_en && (id_wreg == REG_ADDR_W'(i)))) begin
                if (cnt_q[i] == '0) begin
                    dec_udf = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // Scoreboard storage; entry 0 is reset to zero and never written otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Operand pending detection from the registered counts.
    always_comb begin
        rs_busy = (cnt_q[id_rs] != '0);
        rt_busy = (cnt_q[id_rt] != '0);
`ifdef HAZ_WB_BYPASS_EN
        // Last outstanding writer is retiring right now: the value lands in the
        // register file early enough for ID to read it this cycle.
        rs_pend = rs_busy && !(wb_regwe && (wb_wreg == id_rs) &&
                               (cnt_q[id_rs] == CNT_W'(1)));
        rt_pend = rt_busy && !(wb_regwe && (wb_wreg == id_rt) &&
                               (cnt_q[id_rt] == CNT_W'(1)));
`else
        rs_pend = rs_busy;
        rt_pend = rt_busy;
`endif
    end

    // FSM next state: pause_req beats branch_taken, FLUSH lasts one cycle.
    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_FLUSH: state_d = ST_RUN;
            default: begin
                if (pause_req) begin
                    state_d = ST_STALL;
                end else if (branch_taken) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall-cycle counter next state, saturating at all-ones.
    always_comb begin
        perf_d = perf_q;
        if (pause_req && !in_flush && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    // Pipeline control outputs; reset forces a frozen front end and a bubble.
    always_comb begin
        pause       = 2'b00;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (in_flush) begin
            // ID holds the squashed slot: refill the front end, bubble EX.
            idex_bubble = 1'b1;
        end else begin
            if (id_valid) begin
                pause = {rt_pend, rs_pend};
            end
            // RUN and STALL share identical output decoding.
            if (pause_req) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
            end
        end
    end

    assign perf_stall_cnt = perf_q;

    // Saturation on either side means the pipeline lost track of a writer.
    a_no_cnt_overflow: assert property (@(posedge clk) disable iff (rst) !inc_ovf);
    a_no_cnt_underflow: assert property (@(posedge clk) disable iff (rst) !dec_udf);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. The bench plays the role of the
// control unit, driving pause_req and branch_taken by hand. Every expected
// value below is worked out by hand from the intended behaviour.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_wreg;
    logic        id_regwe;
    logic        pause_req;
    logic        branch_taken;
    logic        wb_regwe;
    logic [4:0]  wb_wreg;
    logic [1:0]  pause;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [15:0] perf_stall_cnt;

    int checks;
    int failures;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (5),
        .CNT_W      (2),
        .PERF_W     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_wreg        (id_wreg),
        .id_regwe       (id_regwe),
        .pause_req      (pause_req),
        .branch_taken   (branch_taken),
        .wb_regwe       (wb_regwe),
        .wb_wreg        (wb_wreg),
        .pause          (pause),
        .pc_we          (pc_we),
        .ifid_we        (ifid_we),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] wreg, input logic we);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_wreg  = wreg;
        id_regwe = we;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] wreg);
        wb_regwe = we;
        wb_wreg  = wreg;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_wb(1'b0, 5'd0);
        pause_req    = 1'b0;
        branch_taken = 1'b0;
    endtask

    // Check the four pipeline control outputs at once.
    task automatic chk_ctl(input string tag, input logic pc, input logic ifid,
                           input logic fl, input logic bub);
        chk({tag, ".pc_we"}, 32'(pc_we), 32'(pc));
        chk({tag, ".ifid_we"}, 32'(ifid_we), 32'(ifid));
        chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
        chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        #2;
        chk_ctl("rst0", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst0.pause", 32'(pause), 32'd0);
        chk("rst0.perf", 32'(perf_stall_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_ctl("run_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // RAW: addu $3,$1,$2 then addu $4,$3,$0
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        #1;
        chk("raw.issue.pause", 32'(pause), 32'd0);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 5'd4, 1'b1);
        #1;
        chk("raw.dep.pause", 32'(pause), 32'd1);
        pause_req = 1'b1;
        #1;
        chk_ctl("raw.stall", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_wb(1'b1, 5'd3);
        #1;
`ifdef HAZ_WB_BYPASS_EN
        chk("raw.wbcycle.pause", 32'(pause), 32'd0);
`else
        chk("raw.wbcycle.pause", 32'(pause), 32'd1);
`endif
        chk("raw.perf1", 32'(perf_stall_cnt), 32'd1);
        chk_ctl("raw.stall2", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_wb(1'b0, 5'd0);
        pause_req = 1'b0;
        #1;
        chk("raw.after_wb.pause", 32'(pause), 32'd0);
        chk("raw.perf2", 32'(perf_stall_cnt), 32'd2);
        chk_ctl("raw.resume", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        set_wb(1'b1, 5'd4);
        tick();
        idle();

        // Back-to-back writers to $7: 1, 2, 1, then same-cycle issue+WB, then 0
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        #1;
        chk("r7.first.pause", 32'(pause), 32'd0);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 5'd7, 1'b1);
        #1;
        chk("r7.cnt1.pause", 32'(pause), 32'd1);
        tick();
        set_id(1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
        set_wb(1'b1, 5'd7);
        #1;
        chk("r7.cnt2_wb.pause", 32'(pause), 32'd3);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 5'd7, 1'b1);
        set_wb(1'b1, 5'd7);
        #1;
`ifdef HAZ_WB_BYPASS_EN
        chk("r7.cnt1_wb.pause", 32'(pause), 32'd0);
`else
        chk("r7.cnt1_wb.pause", 32'(pause), 32'd1);
`endif
        tick();
        set_id(1'b1, 5'd0, 5'd7, 5'd0, 1'b0);
        set_wb(1'b0, 5'd0);
        #1;
        chk("r7.unchanged.pause", 32'(pause), 32'd2);
        tick();
        set_wb(1'b1, 5'd7);
        #1;
`ifdef HAZ_WB_BYPASS_EN
        chk("r7.last_wb.pause", 32'(pause), 32'd0);
`else
        chk("r7.last_wb.pause", 32'(pause), 32'd2);
`endif
        tick();
        set_wb(1'b0, 5'd0);
        #1;
        chk("r7.clear.pause", 32'(pause), 32'd0);
        tick();

        // Writer to $0 never creates a hazard
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0);
        #1;
        chk("r0.pause", 32'(pause), 32'd0);
        chk_ctl("r0.ctl", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Taken branch in RUN: flush now, FLUSH next cycle, then RUN
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        branch_taken = 1'b1;
        #1;
        chk_ctl("br.take", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        branch_taken = 1'b0;
        set_id(1'b1, 5'd9, 5'd9, 5'd9, 1'b1);
        pause_req = 1'b1;
        #1;
        chk_ctl("br.flush", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("br.flush.pause", 32'(pause), 32'd0);
        tick();
        pause_req = 1'b0;
        set_id(1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        #1;
        chk("br.noissue.pause", 32'(pause), 32'd0);
        chk_ctl("br.back_run", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("br.perf", 32'(perf_stall_cnt), 32'd2);
        tick();

        // Stalled branch: 3 stall cycles, then flush when pause_req drops
        idle();
        branch_taken = 1'b1;
        pause_req    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ctl("sbr.stall", 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        pause_req = 1'b0;
        #1;
        chk("sbr.perf", 32'(perf_stall_cnt), 32'd5);
        chk_ctl("sbr.take", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        branch_taken = 1'b0;
        #1;
        chk_ctl("sbr.flush", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        #1;
        chk_ctl("sbr.run", 1'b1, 1'b1, 1'b0, 1'b0);

        // Mid-run reset with cnt[5] = 2
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd5, 1'b1);
        #1;
        chk("mrst.cnt1.pause", 32'(pause), 32'd1);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        pause_req = 1'b1;
        #1;
        chk("mrst.cnt2.pause", 32'(pause), 32'd3);
        tick();
        #1;
        chk("mrst.perf_before", 32'(perf_stall_cnt), 32'd6);
        rst = 1'b1;
        #1;
        chk("mrst.pause", 32'(pause), 32'd0);
        chk("mrst.perf", 32'(perf_stall_cnt), 32'd0);
        chk_ctl("mrst.ctl", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst       = 1'b0;
        pause_req = 1'b0;
        #1;
        chk("mrst.after.pause", 32'(pause), 32'd0);
        chk_ctl("mrst.after.ctl", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        #1;
        chk("mrst.after.perf", 32'(perf_stall_cnt), 32'd0);
        chk("mrst.after.pause2", 32'(pause), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Scoreboard-based hazard and stall sequencer for the 5-stage MIPS pipeline; sits beside the ID stage.
- Tracks in-flight destination registers from ID issue to WB and drives the 2-bit pause code into control_unit.pause_in.
- Takes control_unit.pause_out plus the taken-branch indication and generates the PC / IF-ID / ID-EX enables, flush and bubble.
- Counts stall cycles for performance debug.

Parameters:
REG_ADDR_W, 5, register address width (32 GPRs, r0 never pending)
CNT_W, 2, width of the per-register in-flight counter (max 3 writers in EX/MEM/WB)
PERF_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_ADDR_W  rs field of the ID instruction
id_rt  input  REG_ADDR_W  rt field of the ID instruction
id_wreg  input  REG_ADDR_W  resolved destination register (after WriteRegSrc mux)
id_regwe  input  1  ID instruction writes the register file (control_unit RegWE)
pause_req  input  1  control_unit pause_out
branch_taken  input  1  control_unit PCsrc != PFU_OP_NEXT
wb_regwe  input  1  WB stage register write enable
wb_wreg  input  REG_ADDR_W  WB stage destination register
pause  output  2  00 PAUSE_NO, 01 PAUSE_RS, 10 PAUSE_RT, 11 both pending
pc_we  output  1  PC register enable
ifid_we  output  1  IF/ID pipeline register enable
ifid_flush  output  1  load a NOP into IF/ID on this edge
idex_bubble  output  1  load a NOP into ID/EX on this edge
perf_stall_cnt  output  PERF_W  saturating count of stall cycles

Behaviour:
- Scoreboard: cnt[1..31], each CNT_W bits; cnt[0] is hard-wired to 0.
- issue = id_valid && !pause_req && state != FLUSH.
- Increment cnt[id_wreg] on issue && id_regwe && id_wreg != 0.
- Decrement cnt[wb_wreg] on wb_regwe && wb_wreg != 0.
- Increment and decrement of the same entry in the same cycle: entry unchanged.
- Increment saturates at all-ones; decrement saturates at 0. Neither is a legal pipeline event; both are flagged by simulation assertions.
- pause[0] = (cnt[id_rs] != 0); pause[1] = (cnt[id_rt] != 0). Reads registered counts, so a WB-cycle clear is visible next cycle.
- In state FLUSH, or when id_valid = 0, pause = 00.
- FSM states: RUN, STALL, FLUSH; state is not exported.
- RUN:
  - pause_req = 1: go to STALL; pc_we = 0, ifid_we = 0, idex_bubble = 1.
  - else branch_taken = 1: go to FLUSH; pc_we = 1, ifid_we = 1, ifid_flush = 1.
  - else stay in RUN; pc_we = 1, ifid_we = 1, others 0.
- STALL:
  - Outputs identical to RUN for the same inputs; the state only marks stall occupancy.
  - pause_req = 0 with branch_taken = 1: go to FLUSH.
  - pause_req = 0 otherwise: go to RUN.
- FLUSH:
  - ID holds the squashed slot: no issue, no stall.
  - pc_we = 1, ifid_we = 1, ifid_flush = 0, idex_bubble = 1.
  - Always returns to RUN after one cycle.
- pause_req has priority over branch_taken: a stalled branch is not taken until its operands are ready.
- perf_stall_cnt increments every cycle pause_req = 1 && state != FLUSH, and saturates at all-ones.
- Reset, asynchronous and legal mid-operation:
  - All cnt entries = 0, state = RUN, perf_stall_cnt = 0.
  - While rst = 1: pc_we = 0, ifid_we = 0, ifid_flush = 0, idex_bubble = 1, pause = 00.
  - The first edge after rst deasserts behaves as RUN.

Optional Feature:
- Macro HAZ_WB_BYPASS_EN.
- When defined, pause ignores a register whose count is 1 and which is being written back this cycle (wb_regwe && wb_wreg matches). This models a register file that writes in the first half-cycle and removes one stall cycle per RAW hazard.
- When undefined, pause uses only the registered counts; this is the baseline described above.
- Scoreboard update rules are identical in both builds.

Test Plan:
- Reset mid-run with cnt[5] = 2: assert rst -> next cycle all pause = 00, perf_stall_cnt = 0, pc_we = 0, idex_bubble = 1 while rst = 1.
- Issue addu $3,$1,$2 (wreg 3, regwe 1), then ID = addu $4,$3,$0 -> pause = 01 the cycle after issue. pause_req = 1 -> pc_we = 0, ifid_we = 0, idex_bubble = 1. pause returns to 00 the cycle after wb_regwe with wb_wreg = 3; with HAZ_WB_BYPASS_EN it returns in the WB cycle itself.
- Two back-to-back writers to $7, then a WB of $7 -> cnt[7] goes 1, 2, 1. Simultaneous issue to $7 and WB of $7 -> cnt[7] unchanged.
- Writer to $0 (regwe 1, wreg 0), then a reader of $0 -> pause = 00, no stall.
- branch_taken = 1 with pause_req = 0 in RUN -> ifid_flush = 1 that cycle. Next cycle FLUSH: idex_bubble = 1, id_valid ignored (no cnt change), then RUN.
- branch_taken = 1 with pause_req = 1 for 3 cycles -> 3 stall cycles, perf_stall_cnt += 3, then ifid_flush = 1 on the cycle pause_req drops.
